popcount_stream: RTL and testbench

POPCOUNT_STREAM -- requirements
Module: popcount_stream

---
 rtl/popcount_stream.sv | 84 ++++++++
 tb/tb_popcount_stream.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/popcount_stream.sv
// Streaming per-frame popcount: accumulates a saturating total, the largest
// per-word count and a saturation flag, then holds the result until consumed.
module popcount_stream #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 12,
   parameter int CW     = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_total,
   output logic [CW-1:0]     out_max,
   output logic              out_sat
);

   localparam int SW = ACC_W + 1;
   localparam logic [ACC_W-1:0] TOT_MAX = {ACC_W{1'b1}};

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  total;
   logic [CW-1:0]     max_cnt;
   logic              sat;
   logic [CW-1:0]     cnt;
   logic [SW-1:0]     sum;
   logic              accept;
   logic              consume;
   logic              over;

   // XOR with mode turns the ones-count into a zeros-count per beat
   always_comb begin
      cnt = '0;
      for (int i = 0; i < DATA_W; i++)
         cnt = cnt + CW'(in_data[i] ^ mode);
   end

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;
   assign sum       = {1'b0, total} + SW'(cnt);
   assign over      = (sum > {1'b0, TOT_MAX});

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
         HOLD:        if (consume) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         total   <= '0;
         max_cnt <= '0;
         sat     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (consume) begin
            total   <= '0;
            max_cnt <= '0;
            sat     <= 1'b0;
         end else if (accept) begin
            total <= over ? TOT_MAX : sum[ACC_W-1:0];
            if (over) sat <= 1'b1;
            if (cnt > max_cnt) max_cnt <= cnt;
         end
      end
   end

   assign out_total = total;
   assign out_max   = max_cnt;
   assign out_sat   = sat;

endmodule

// File: tb/tb_popcount_stream.sv
// Directed bench for popcount_stream (DATA_W=16, ACC_W=12): vector table plus
// hand sequences for saturation, backpressure and reset corner cases.
module tb_popcount_stream;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 12;
   localparam int CW     = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              mode = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ACC_W-1:0]  out_total;
   logic [CW-1:0]     out_max;
   logic              out_sat;

   int checks = 0;
   int errors = 0;

   popcount_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
      .out_max(out_max), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        mode;
      logic        last;
      int          tot;
      int          mx;
      logic        sat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input int tot, input int mx,
                            input int st, input int vld);
      check({name, ".total"}, int'(out_total), tot);
      check({name, ".max"}, int'(out_max), mx);
      check({name, ".sat"}, int'(out_sat), st);
      check({name, ".valid"}, int'(out_valid), vld);
      check({name, ".ready"}, int'(in_ready), 1 - vld);
   endtask

   task automatic beat(input logic [15:0] d, input logic m, input logic l);
      in_valid = 1'b1; in_data = d; mode = m; in_last = l;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic consume(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_out(name, 0, 0, 0, 0);
   endtask

   int exp_tot;
   int hold_tot, hold_max, hold_sat;

   initial begin
      vecs[0] = '{16'hFFFF, 1'b0, 1'b1, 16, 16, 1'b0};
      vecs[1] = '{16'h00FF, 1'b0, 1'b0,  8,  8, 1'b0};
      vecs[2] = '{16'h0001, 1'b0, 1'b0,  9,  8, 1'b0};
      vecs[3] = '{16'h8000, 1'b0, 1'b1, 10,  8, 1'b0};
      vecs[4] = '{16'h0000, 1'b1, 1'b0, 16, 16, 1'b0};
      vecs[5] = '{16'h000F, 1'b0, 1'b1, 20, 16, 1'b0};
      vecs[6] = '{16'hFFFF, 1'b1, 1'b0,  0,  0, 1'b0};
      vecs[7] = '{16'h1234, 1'b1, 1'b1, 11, 11, 1'b0};
      vecs[8] = '{16'hAAAA, 1'b0, 1'b1,  8,  8, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      check_out("reset", 0, 0, 0, 0);

      for (int i = 0; i < 9; i++) begin
         beat(vecs[i].data, vecs[i].mode, vecs[i].last);
         check_out($sformatf("vec%0d", i), vecs[i].tot, vecs[i].mx,
                   int'(vecs[i].sat), int'(vecs[i].last));
         if (vecs[i].last) consume($sformatf("vec%0d_consume", i));
      end

      // saturation: total must clamp at 4095 and never wrap
      for (int k = 1; k <= 300; k++) begin
         beat(16'hFFFF, 1'b0, k == 300);
         exp_tot = (16 * k > 4095) ? 4095 : 16 * k;
         check($sformatf("sat_total_%0d", k), int'(out_total), exp_tot);
         check($sformatf("sat_flag_%0d", k), int'(out_sat), (16 * k > 4095) ? 1 : 0);
      end
      check_out("sat_final", 4095, 16, 1, 1);
      consume("sat_consume");

      // backpressure: new beats offered while result is pending
      beat(16'h0F00, 1'b0, 1'b0);
      beat(16'h0003, 1'b0, 1'b1);
      check_out("bp_hold", 6, 4, 0, 1);
      hold_tot = int'(out_total); hold_max = int'(out_max); hold_sat = int'(out_sat);
      in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1; mode = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check_out($sformatf("bp_stall%0d", c), hold_tot, hold_max, hold_sat, 1);
      end
      in_valid = 1'b0; in_last = 1'b0;
      consume("bp_consume");
      beat(16'h0007, 1'b0, 1'b1);
      check_out("bp_next", 3, 3, 0, 1);
      consume("bp_next_consume");

      // reset mid-frame, with a beat offered during reset
      beat(16'h0F0F, 1'b0, 1'b0);
      beat(16'h0F0F, 1'b0, 1'b0);
      check_out("mid_accum", 16, 8, 0, 0);
      rst = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      check_out("mid_reset", 0, 0, 0, 0);
      beat(16'h0003, 1'b0, 1'b1);
      check_out("post_reset", 2, 2, 0, 1);

      // reset while holding discards the result
      rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; out_ready = 1'b0;
      check_out("hold_reset", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
